// File: rtl/rat_io_responder_if.sv
// RAT MCU port-mapped I/O bus: address, write data and strobe from the MCU,
// read data and interrupt back to it.
interface rat_io_responder_if;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       io_strb;
   logic [7:0] in_port;
   logic       intr;

   modport master (
      output port_id,
      output out_port,
      output io_strb,
      input  in_port,
      input  intr
   );

   modport slave (
      input  port_id,
      input  out_port,
      input  io_strb,
      output in_port,
      output intr
   );
endinterface

// File: rtl/rat_io_responder.sv
// RAT MCU I/O responder: LED/seven-segment write registers, synchronized switch reads and a
// debounced push-button interrupt. Define IO_INTR_EN to build the button/interrupt path.
module rat_io_responder #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [7:0]  LEDS_LO_ID      = 8'h40,
   parameter logic [7:0]  LEDS_HI_ID      = 8'h41,
   parameter logic [7:0]  SSEG_ID         = 8'h81,
   parameter logic [7:0]  SW_LO_ID        = 8'h20,
   parameter logic [7:0]  SW_HI_ID        = 8'h21,
   parameter logic [7:0]  INTR_STATUS_ID  = 8'h30,
   parameter logic [7:0]  INTR_ACK_ID     = 8'h90
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   rat_io_responder_if.slave         bus,
   input  logic               [15:0] switches_i,
   input  logic                      btn_i,
   output logic               [15:0] leds_o,
   output logic               [7:0]  sseg_val_o
);

   logic [15:0] leds_q, leds_d;
   logic [7:0]  sseg_q, sseg_d;
   logic [15:0] sw_s1_q, sw_s2_q;
   logic [7:0]  intr_status;
   logic        intr;

   always_comb begin
      leds_d = leds_q;
      sseg_d = sseg_q;
      if (bus.io_strb) begin
         if (bus.port_id == LEDS_LO_ID) leds_d[7:0]  = bus.out_port;
         if (bus.port_id == LEDS_HI_ID) leds_d[15:8] = bus.out_port;
         if (bus.port_id == SSEG_ID)    sseg_d       = bus.out_port;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         leds_q  <= '0;
         sseg_q  <= '0;
         sw_s1_q <= '0;
         sw_s2_q <= '0;
      end else begin
         leds_q  <= leds_d;
         sseg_q  <= sseg_d;
         sw_s1_q <= switches_i;
         sw_s2_q <= sw_s1_q;
      end
   end

`ifdef IO_INTR_EN
   typedef enum logic [1:0] {StStableLo, StWaitHi, StStableHi, StWaitLo} db_state_e;

   db_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        btn_s1_q, btn_s2_q;
   logic        rise;
   logic        pending_q, pending_d;
   logic [6:0]  missed_q, missed_d;
   logic        ack_wr;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise    = 1'b0;
      case (state_q)
         StStableLo: begin
            cnt_d = '0;
            if (btn_s2_q) state_d = StWaitHi;
         end
         StWaitHi: begin
            if (!btn_s2_q) begin
               state_d = StStableLo;
               cnt_d   = '0;
            end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
               state_d = StStableHi;
               cnt_d   = '0;
               rise    = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StStableHi: begin
            cnt_d = '0;
            if (!btn_s2_q) state_d = StWaitLo;
         end
         StWaitLo: begin
            if (btn_s2_q) begin
               state_d = StStableHi;
               cnt_d   = '0;
            end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
               state_d = StStableLo;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = StStableLo;
            cnt_d   = '0;
         end
      endcase
   end

   assign ack_wr = bus.io_strb && (bus.port_id == INTR_ACK_ID);

   // A rise in the same cycle as an ack wins: PENDING stays set, MISSED restarts at 0.
   always_comb begin
      pending_d = pending_q;
      missed_d  = missed_q;
      if (ack_wr) begin
         pending_d = 1'b0;
         missed_d  = '0;
      end
      if (rise) begin
         pending_d = 1'b1;
         if (pending_q && !ack_wr && (missed_q != 7'h7F)) missed_d = missed_q + 7'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         btn_s1_q  <= 1'b0;
         btn_s2_q  <= 1'b0;
         state_q   <= StStableLo;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         missed_q  <= '0;
      end else begin
         btn_s1_q  <= btn_i;
         btn_s2_q  <= btn_s1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         missed_q  <= missed_d;
      end
   end

   assign intr_status = {missed_q, pending_q};
   assign intr        = pending_q;
`else
   logic unused_cfg;
   assign unused_cfg  = ^{btn_i, DEBOUNCE_CYCLES, INTR_STATUS_ID, INTR_ACK_ID};
   assign intr_status = 8'h00;
   assign intr        = 1'b0;
`endif

   logic [7:0] in_port;

   always_comb begin
      in_port = 8'h00;
      if (bus.port_id == SW_LO_ID)            in_port = sw_s2_q[7:0];
      else if (bus.port_id == SW_HI_ID)       in_port = sw_s2_q[15:8];
      else if (bus.port_id == INTR_STATUS_ID) in_port = intr_status;
   end

   assign bus.in_port = in_port;
   assign bus.intr    = intr;
   assign leds_o      = leds_q;
   assign sseg_val_o  = sseg_q;

endmodule
